// File: rtl/uart_transmitter_gen.sv
// Parametrised UART transmitter: DATA_W data bits, optional even/odd parity,
// 1/1.5/2 stop bits, request/acknowledge handshake, per-frame configuration latch.
module uart_transmitter_gen #(
    parameter int DATA_W = 8,
    parameter int COMP_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tr_en,
    input  logic              tx_req,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [COMP_W-1:0] comp,
    input  logic [1:0]        stop_sel,
    input  logic [1:0]        par_sel,
    output logic              tx_req_ack,
    output logic              busy,
    output logic              uart_tx
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [COMP_W:0] CNT_ONE = 1;
    localparam logic [BIT_W-1:0] BIT_ONE = 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] data_q;
    logic [COMP_W-1:0] comp_q;
    logic [1:0]        stop_q;
    logic [1:0]        par_q;
    logic [COMP_W:0]   cnt, cnt_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic              load;
    logic              tx_n;
    logic              ack_n;
    logic              data_bit;

    logic [COMP_W:0] comp_ext;
    logic [COMP_W:0] half_period;
    logic [COMP_W:0] stop_last;
    logic            bit_done;
    logic            parity_on;
    logic            parity_bit;

    assign comp_ext    = {1'b0, comp_q};
    assign half_period = (comp_ext + CNT_ONE) >> 1;
    assign bit_done    = (cnt == comp_ext);
    assign parity_on   = (par_q == 2'b01) || (par_q == 2'b10);
    assign parity_bit  = (par_q == 2'b10) ? ~^data_q : ^data_q;

    // Terminal count of the stop phase; the extra counter bit covers 2*(comp+1)-1.
    always_comb begin
        case (stop_q)
            2'b00:   stop_last = comp_ext;
            2'b01:   stop_last = comp_ext + half_period;
            default: stop_last = {comp_q, 1'b1};
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_n   = state;
        cnt_n     = cnt + CNT_ONE;
        bit_cnt_n = bit_cnt;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (tr_en && tx_req) begin
                    state_n = S_START;
                    load    = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        state_n   = parity_on ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_n = S_STOP;
                    cnt_n   = '0;
                end
            end
            S_STOP: begin
                if (cnt == stop_last) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        // Dropping the enable mid-frame abandons the frame without an acknowledge.
        if (state != S_IDLE && !tr_en) begin
            state_n   = S_IDLE;
            cnt_n     = '0;
            bit_cnt_n = '0;
        end
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        data_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_n == BIT_W'(i)) data_bit = data_q[i];
        end
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = data_bit;
            S_PARITY: tx_n = parity_bit;
            default:  tx_n = 1'b1;
        endcase
        ack_n = (state_n == S_WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            comp_q     <= '0;
            stop_q     <= '0;
            par_q      <= '0;
            uart_tx    <= 1'b1;
            tx_req_ack <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            uart_tx    <= tx_n;
            tx_req_ack <= ack_n;
            if (load) begin
                data_q <= tx_data;
                comp_q <= comp;
                stop_q <= stop_sel;
                par_q  <= par_sel;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_transmitter_gen.sv
// Self-checking bench for uart_transmitter_gen: frame table, hand-written corner
// sequences and randomized frames against a bit-list reference model.
module tb_uart_transmitter_gen;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tr_en;
    logic       tx_req8, tx_req5;
    logic [7:0] tx_data8;
    logic [4:0] tx_data5;
    logic [15:0] comp;
    logic [1:0] stop_sel, par_sel;
    logic       ack8, busy8, tx8;
    logic       ack5, busy5, tx5;

    always #5 clk = ~clk;

    uart_transmitter_gen #(.DATA_W(8), .COMP_W(16)) dut (
        .clk(clk), .resetn(resetn), .tr_en(tr_en), .tx_req(tx_req8),
        .tx_data(tx_data8), .comp(comp), .stop_sel(stop_sel), .par_sel(par_sel),
        .tx_req_ack(ack8), .busy(busy8), .uart_tx(tx8)
    );

    uart_transmitter_gen #(.DATA_W(5), .COMP_W(16)) dut5 (
        .clk(clk), .resetn(resetn), .tr_en(tr_en), .tx_req(tx_req5),
        .tx_data(tx_data5), .comp(comp), .stop_sel(stop_sel), .par_sel(par_sel),
        .tx_req_ack(ack5), .busy(busy5), .uart_tx(tx5)
    );

    int vectors = 0;
    int miscompares = 0;
    bit exp_q[$];

    typedef struct {
        bit         w5;
        logic [8:0] data;
        int         comp_v;
        logic [1:0] stop;
        logic [1:0] par;
        int         n_exp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line level for every cycle from the acceptance edge up to (not including) WAIT.
    function automatic void build_frame(input logic [8:0] data, input int dw, input int comp_v,
                                        input logic [1:0] stop, input logic [1:0] par);
        int p, ones, stop_len;
        p = comp_v + 1;
        ones = 0;
        exp_q.delete();
        repeat (p) exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            ones += int'(data[i]);
            repeat (p) exp_q.push_back(data[i]);
        end
        if (par == 2'b01) repeat (p) exp_q.push_back(bit'(ones % 2));
        if (par == 2'b10) repeat (p) exp_q.push_back(bit'(1 - ones % 2));
        case (stop)
            2'b00:   stop_len = p;
            2'b01:   stop_len = p + p / 2;
            default: stop_len = 2 * p;
        endcase
        repeat (stop_len) exp_q.push_back(1'b1);
    endfunction

    function automatic logic [2:0] sample(input bit w5);
        return w5 ? {tx5, ack5, busy5} : {tx8, ack8, busy8};
    endfunction

    task automatic run_frame(input bit w5, input logic [8:0] data, input int comp_v,
                             input logic [1:0] stop, input logic [1:0] par,
                             input bit scramble, input int n_exp, input string name);
        int n, bad, ack_k;
        logic [2:0] s, e, bad_a, bad_e;
        build_frame(data, w5 ? 5 : 8, comp_v, stop, par);
        n = exp_q.size() + 1;
        bad = -1;
        ack_k = -1;
        s = '0;
        @(negedge clk);
        tr_en = 1'b1;
        comp = 16'(comp_v);
        stop_sel = stop;
        par_sel = par;
        if (w5) begin
            tx_data5 = data[4:0];
            tx_req5 = 1'b1;
        end else begin
            tx_data8 = data[7:0];
            tx_req8 = 1'b1;
        end
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            s = sample(w5);
            if (k < n - 1) e = {exp_q[k], 1'b0, 1'b1};
            else if (k == n - 1) e = 3'b111;
            else e = 3'b100;
            if (s[1] && ack_k < 0) ack_k = k;
            if (s !== e && bad < 0) begin
                bad = k;
                bad_a = s;
                bad_e = e;
            end
            if (k == n - 1) begin
                tx_req8 = 1'b0;
                tx_req5 = 1'b0;
            end else if (scramble) begin
                tx_data8 = 8'($urandom);
                tx_data5 = 5'($urandom);
                comp = 16'($urandom_range(0, 7));
                stop_sel = 2'($urandom);
                par_sel = 2'($urandom);
            end
        end
        if (bad >= 0) check($sformatf("%s line/ack/busy cycle %0d", name, bad), bad_a, bad_e);
        else check($sformatf("%s final idle", name), s, 3'b100);
        check($sformatf("%s ack cycle", name), ack_k + 1, n_exp);
    endtask

    initial begin
        int acks, busies, n, s2, gap, bad;
        logic [2:0] s, e;
        bit line[64];

        tbl[0] = '{0, 9'h0A5, 3, 2'b00, 2'b00, 41};
        tbl[1] = '{0, 9'h007, 3, 2'b00, 2'b01, 45};
        tbl[2] = '{0, 9'h007, 3, 2'b00, 2'b10, 45};
        tbl[3] = '{0, 9'h03C, 3, 2'b01, 2'b00, 43};
        tbl[4] = '{0, 9'h03C, 3, 2'b10, 2'b00, 45};
        tbl[5] = '{0, 9'h03C, 3, 2'b11, 2'b00, 45};
        tbl[6] = '{1, 9'h01F, 3, 2'b00, 2'b01, 33};
        tbl[7] = '{0, 9'h081, 0, 2'b01, 2'b10, 12};
        tbl[8] = '{0, 9'h0FF, 0, 2'b10, 2'b01, 13};

        resetn = 1'b0;
        tr_en = 1'b0;
        tx_req8 = 1'b0;
        tx_req5 = 1'b0;
        tx_data8 = '0;
        tx_data5 = '0;
        comp = '0;
        stop_sel = '0;
        par_sel = '0;
        repeat (3) @(negedge clk);
        check("reset state", {tx8, ack8, busy8}, 3'b100);
        resetn = 1'b1;
        @(negedge clk);
        check("idle after reset", {tx8, ack8, busy8, tx5, ack5, busy5}, 6'b100100);

        for (int i = 0; i < 9; i++)
            run_frame(tbl[i].w5, tbl[i].data, tbl[i].comp_v, tbl[i].stop, tbl[i].par, 1'b0,
                      tbl[i].n_exp, $sformatf("tbl%0d", i));

        // Enable low in IDLE: requests are ignored.
        tr_en = 1'b0;
        tx_req8 = 1'b1;
        busies = 0;
        repeat (10) begin
            @(negedge clk);
            busies += int'(busy8);
        end
        check("tr_en low ignores req", busies, 0);
        tx_req8 = 1'b0;
        tr_en = 1'b1;

        // Asynchronous reset in the middle of DATA.
        @(negedge clk);
        tx_data8 = 8'hA5;
        comp = 16'd3;
        stop_sel = 2'b00;
        par_sel = 2'b00;
        tx_req8 = 1'b1;
        repeat (12) @(negedge clk);
        #2 resetn = 1'b0;
        #1 check("reset mid-frame", {tx8, ack8, busy8}, 3'b100);
        tx_req8 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        acks = 0;
        busies = 0;
        repeat (50) begin
            @(negedge clk);
            acks += int'(ack8);
            busies += int'(busy8);
        end
        check("no ack after reset", acks, 0);
        check("no busy after reset", busies, 0);
        run_frame(0, 9'h0A5, 3, 2'b00, 2'b00, 1'b0, 41, "post-reset frame");

        // Abort by dropping tr_en during data bit 3.
        @(negedge clk);
        tx_data8 = 8'hA5;
        comp = 16'd3;
        stop_sel = 2'b00;
        par_sel = 2'b00;
        tx_req8 = 1'b1;
        repeat (18) @(negedge clk);
        tr_en = 1'b0;
        tx_req8 = 1'b0;
        @(negedge clk);
        check("abort next cycle", {tx8, ack8, busy8}, 3'b100);
        tr_en = 1'b1;
        acks = 0;
        repeat (45) begin
            @(negedge clk);
            acks += int'(ack8);
        end
        check("no ack after abort", acks, 0);
        run_frame(0, 9'h0A5, 3, 2'b00, 2'b00, 1'b0, 41, "post-abort frame");

        // Back-to-back frames with tx_req held high, comp=0.
        build_frame(9'h055, 8, 0, 2'b00, 2'b00);
        n = exp_q.size() + 1;
        @(negedge clk);
        tx_data8 = 8'h55;
        comp = 16'd0;
        stop_sel = 2'b00;
        par_sel = 2'b00;
        tx_req8 = 1'b1;
        acks = 0;
        bad = -1;
        for (int k = 0; k <= 2 * n + 1; k++) begin
            int j;
            @(negedge clk);
            s = {tx8, ack8, busy8};
            line[k] = tx8;
            acks += int'(ack8);
            j = (k > n) ? k - n - 1 : k;
            if (k == n) e = 3'b100;
            else if (j < n - 1) e = {exp_q[j], 1'b0, 1'b1};
            else if (j == n - 1) e = 3'b111;
            else e = 3'b100;
            if (s !== e && bad < 0) begin
                bad = k;
                check($sformatf("b2b line/ack/busy cycle %0d", k), s, e);
            end
            if (k == 2 * n) tx_req8 = 1'b0;
        end
        if (bad < 0) check("b2b final idle", s, 3'b100);
        check("b2b ack count", acks, 2);
        s2 = -1;
        for (int k = n; k < 2 * n + 2; k++)
            if (s2 < 0 && line[k] == 1'b0) s2 = k;
        gap = 0;
        for (int k = s2 - 1; k >= 0 && s2 > 0; k--) begin
            if (line[k] == 1'b0) break;
            gap++;
        end
        check("b2b high gap", gap, 3);

        // Randomized frames; inputs are scrambled every cycle while a frame runs.
        for (int i = 0; i < 30; i++) begin
            logic [8:0] d;
            int c, len;
            logic [1:0] st, pa;
            d = 9'($urandom);
            c = $urandom_range(0, 4);
            st = 2'($urandom);
            pa = 2'($urandom);
            build_frame(d, 8, c, st, pa);
            len = exp_q.size() + 1;
            run_frame(0, d, c, st, pa, 1'b1, len, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
